// File: rtl/id_decode_seq.sv
// Instruction decode sequencer: fetches opcode + operand bytes, looks up the uop ROM, offers one entry to the station.
// Optional branch-redirect flush input enabled by defining ID_FLUSH_EN.
module id_decode_seq #(
   parameter int               UOP_W   = 20,
   parameter logic [UOP_W-1:0] NOP_UOP = 20'b0000_0000_1111_00_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       pf_byte,
   input  logic             pf_valid,
   output logic             pf_ack,
   output logic [7:0]       rom_addr,
   input  logic [63:0]      rom_data,
   input  logic             id_feed_req,
`ifdef ID_FLUSH_EN
   input  logic             id_flush,
`endif
   output logic [UOP_W-1:0] id_uop_0,
   output logic [UOP_W-1:0] id_uop_1,
   output logic [UOP_W-1:0] id_uop_2,
   output logic [1:0]       id_uop_count,
   output logic [15:0]      id_k16,
   output logic             id_illegal
);

   localparam int SLOTS = 3;

   typedef enum logic [2:0] {S_OPC, S_ROM, S_LO, S_HI, S_ISSUE} state_t;

   state_t                       state, state_nxt;
   logic   [7:0]                 rom_addr_q;
   logic   [1:0]                 len_q, cnt_q;
   logic   [SLOTS-1:0][UOP_W-1:0] uop_q, uop_o;
   logic   [7:0]                 lo_q;
   logic   [15:0]                k16_q;
   logic                         ack, ill, flush;

   wire [1:0] rom_len = rom_data[63:62];
   wire [1:0] rom_cnt = rom_data[61:60];

`ifdef ID_FLUSH_EN
   assign flush = id_flush;
`else
   assign flush = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      ack       = 1'b0;
      ill       = 1'b0;
      case (state)
         S_OPC: begin
            ack = pf_valid;
            if (pf_valid) state_nxt = S_ROM;
         end
         S_ROM: begin
            if (rom_cnt == 2'd0) begin
               ill       = 1'b1;
               state_nxt = S_OPC;
            end else if (rom_len == 2'b00) begin
               state_nxt = S_ISSUE;
            end else begin
               state_nxt = S_LO;
            end
         end
         S_LO: begin
            ack = pf_valid;
            if (pf_valid) state_nxt = (len_q == 2'b10) ? S_HI : S_ISSUE;
         end
         S_HI: begin
            ack = pf_valid;
            if (pf_valid) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            // no opcode fetch overlaps an offered entry
            if (id_feed_req) state_nxt = S_OPC;
         end
         default: state_nxt = S_OPC;
      endcase
      // a redirect drops the partial instruction and must not swallow a byte
      if (flush) begin
         state_nxt = S_OPC;
         ack       = 1'b0;
         ill       = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_OPC;
         rom_addr_q <= 8'h00;
         len_q      <= 2'b00;
         cnt_q      <= 2'd0;
         uop_q      <= {SLOTS{NOP_UOP}};
         lo_q       <= 8'h00;
         k16_q      <= 16'h0000;
      end else begin
         state <= state_nxt;
         if (state == S_OPC && ack)
            rom_addr_q <= pf_byte;
         if (state == S_ROM && !flush) begin
            len_q    <= rom_len;
            cnt_q    <= rom_cnt;
            uop_q[0] <= rom_data[59:40];
            uop_q[1] <= rom_data[39:20];
            uop_q[2] <= rom_data[19:0];
            if (rom_cnt != 2'd0 && rom_len == 2'b00)
               k16_q <= 16'h0000;
         end
         if (state == S_LO && ack) begin
            lo_q <= pf_byte;
            case (len_q)
               2'b01:   k16_q <= {8'h00, pf_byte};
               2'b11:   k16_q <= {{8{pf_byte[7]}}, pf_byte};
               default: ;
            endcase
         end
         if (state == S_HI && ack)
            k16_q <= {pf_byte, lo_q};
         if (flush) begin
            cnt_q <= 2'd0;
            uop_q <= {SLOTS{NOP_UOP}};
         end
      end
   end

   // slots at or beyond the count carry the filler uop
   for (genvar i = 0; i < SLOTS; i++) begin : g_slot
      assign uop_o[i] = (state == S_ISSUE && 2'(i) < cnt_q) ? uop_q[i] : NOP_UOP;
   end

   assign id_uop_0     = uop_o[0];
   assign id_uop_1     = uop_o[1];
   assign id_uop_2     = uop_o[2];
   assign id_uop_count = (state == S_ISSUE) ? cnt_q : 2'd0;
   assign id_k16       = k16_q;
   assign id_illegal   = ill;
   assign pf_ack       = ack;
   assign rom_addr     = rom_addr_q;

endmodule

// File: tb/tb_id_decode_seq.sv
// Bench for id_decode_seq: directed table, hand-written corner sequences and a randomized instruction stream.
module tb_id_decode_seq;
   localparam logic [19:0] NOP = 20'b0000_0000_1111_00_000_000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  pf_byte = 8'h00;
   logic        pf_valid = 1'b0;
   logic        pf_ack;
   logic [7:0]  rom_addr;
   logic [63:0] rom_data;
   logic        id_feed_req = 1'b0;
`ifdef ID_FLUSH_EN
   logic        id_flush = 1'b0;
`endif
   logic [19:0] u0, u1, u2;
   logic [1:0]  cnt;
   logic [15:0] k16;
   logic        ill;

   logic [63:0] rom [256];
   assign rom_data = rom[rom_addr];

   id_decode_seq dut (
      .clk(clk), .rst(rst), .pf_byte(pf_byte), .pf_valid(pf_valid), .pf_ack(pf_ack),
      .rom_addr(rom_addr), .rom_data(rom_data), .id_feed_req(id_feed_req),
`ifdef ID_FLUSH_EN
      .id_flush(id_flush),
`endif
      .id_uop_0(u0), .id_uop_1(u1), .id_uop_2(u2), .id_uop_count(cnt),
      .id_k16(k16), .id_illegal(ill)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ill;
      logic [1:0]  cnt;
      logic [15:0] k16;
      logic [19:0] u0, u1, u2;
   } exp_t;

   typedef struct {
      logic [7:0]  opc;
      logic [63:0] word;
      int          nb;
      logic [7:0]  lo, hi;
      logic        ill;
      logic [1:0]  cnt;
      logic [15:0] k16;
      logic [19:0] u0, u1, u2;
   } vec_t;

   int         checks = 0;
   int         errors = 0;
   int         acks   = 0;
   bit         mon_en = 1'b0;
   exp_t       exp_q[$];
   logic [7:0] byte_q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic bad(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: got an event, expected none", nm);
   endtask

   function automatic logic [63:0] rw(input logic [1:0] len, input logic [1:0] c,
                                      input logic [19:0] a, input logic [19:0] b, input logic [19:0] d);
      return {len, c, a, b, d};
   endfunction

   // Expected station entry straight from the ROM word and operand bytes.
   function automatic exp_t model(input logic [63:0] w, input logic [7:0] lo, input logic [7:0] hi);
      exp_t e;
      e.ill = (w[61:60] == 2'd0);
      e.cnt = w[61:60];
      case (w[63:62])
         2'd0:    e.k16 = 16'h0000;
         2'd1:    e.k16 = {8'h00, lo};
         2'd2:    e.k16 = {hi, lo};
         default: e.k16 = 16'($signed(lo));
      endcase
      e.u0 = (e.cnt > 0) ? w[59:40] : NOP;
      e.u1 = (e.cnt > 1) ? w[39:20] : NOP;
      e.u2 = (e.cnt > 2) ? w[19:0]  : NOP;
      return e;
   endfunction

   task automatic push_instr(input logic [7:0] opc, input logic [7:0] lo, input logic [7:0] hi);
      logic [63:0] w;
      w = rom[opc];
      byte_q.push_back(opc);
      if (w[61:60] != 2'd0) begin
         if (w[63:62] != 2'd0) byte_q.push_back(lo);
         if (w[63:62] == 2'd2) byte_q.push_back(hi);
      end
      exp_q.push_back(model(w, lo, hi));
   endtask

   // One clock: drive at negedge, sample 1ns later, well before the posedge.
   task automatic step(input bit v, input bit fr, input bit r = 1'b0, input bit f = 1'b0);
      exp_t e;
      @(negedge clk);
      rst         = r;
      pf_valid    = v && (byte_q.size() != 0);
      pf_byte     = (byte_q.size() != 0) ? byte_q[0] : 8'h00;
      id_feed_req = fr;
`ifdef ID_FLUSH_EN
      id_flush    = f;
`else
      if (f) bad("flush_unsupported");
`endif
      #1;
      if (pf_ack) begin
         acks++;
         chk("ack_needs_valid", 64'(pf_valid), 64'd1);
         if (byte_q.size() != 0) void'(byte_q.pop_front());
      end
      if (mon_en) begin
         if (ill) begin
            if (exp_q.size() == 0) bad("illegal_unexpected");
            else begin
               chk("illegal_expected", 64'(exp_q[0].ill), 64'd1);
               chk("illegal_cnt0", 64'(cnt), 64'd0);
               void'(exp_q.pop_front());
            end
         end else if (cnt != 2'd0) begin
            if (exp_q.size() == 0) bad("issue_unexpected");
            else begin
               e = exp_q[0];
               chk("issue_not_illegal", 64'(e.ill), 64'd0);
               chk("issue_cnt", 64'(cnt), 64'(e.cnt));
               chk("issue_k16", 64'(k16), 64'(e.k16));
               chk("issue_uop0", 64'(u0), 64'(e.u0));
               chk("issue_uop1", 64'(u1), 64'(e.u1));
               chk("issue_uop2", 64'(u2), 64'(e.u2));
               if (id_feed_req) void'(exp_q.pop_front());
            end
         end else begin
            chk("idle_nop", 64'({u0, u1, u2}), 64'({NOP, NOP, NOP}));
         end
      end
   endtask

   task automatic drain(input int budget, input int pv, input int fr);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step($urandom_range(99) < pv, $urandom_range(99) < fr);
         n++;
      end
      chk("drain_done", 64'(exp_q.size()), 64'd0);
      chk("bytes_consumed", 64'(byte_q.size()), 64'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   vec_t tbl[9];
   int   a0;

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = 64'h0;

      tbl[0] = '{8'hEA, rw(2'd0, 2'd1, 20'h12345, 20'hAAAAA, 20'h55555), 0, 8'h00, 8'h00, 1'b0, 2'd1, 16'h0000, 20'h12345, NOP, NOP};
      tbl[1] = '{8'hAD, rw(2'd2, 2'd3, 20'h11111, 20'h22222, 20'h33333), 2, 8'h34, 8'h12, 1'b0, 2'd3, 16'h1234, 20'h11111, 20'h22222, 20'h33333};
      tbl[2] = '{8'hD0, rw(2'd3, 2'd2, 20'hABCDE, 20'h13579, 20'hFFFFF), 1, 8'hFE, 8'h00, 1'b0, 2'd2, 16'hFFFE, 20'hABCDE, 20'h13579, NOP};
      tbl[3] = '{8'hD0, rw(2'd1, 2'd2, 20'hABCDE, 20'h13579, 20'hFFFFF), 1, 8'hFE, 8'h00, 1'b0, 2'd2, 16'h00FE, 20'hABCDE, 20'h13579, NOP};
      tbl[4] = '{8'h02, rw(2'd2, 2'd0, 20'h0F0F0, 20'h0F0F0, 20'h0F0F0), 0, 8'h00, 8'h00, 1'b1, 2'd0, 16'h0000, NOP, NOP, NOP};
      tbl[5] = '{8'hEA, rw(2'd0, 2'd1, 20'h12345, 20'hAAAAA, 20'h55555), 0, 8'h00, 8'h00, 1'b0, 2'd1, 16'h0000, 20'h12345, NOP, NOP};
      tbl[6] = '{8'h7F, rw(2'd3, 2'd1, 20'h00001, 20'h00002, 20'h00003), 1, 8'h7F, 8'h00, 1'b0, 2'd1, 16'h007F, 20'h00001, NOP, NOP};
      tbl[7] = '{8'h80, rw(2'd3, 2'd3, 20'h80000, 20'h40000, 20'h20000), 1, 8'h80, 8'h00, 1'b0, 2'd3, 16'hFF80, 20'h80000, 20'h40000, 20'h20000};
      tbl[8] = '{8'h41, rw(2'd2, 2'd1, 20'h77777, 20'h66666, 20'h55555), 2, 8'h00, 8'hFF, 1'b0, 2'd1, 16'hFF00, 20'h77777, NOP, NOP};

      // reset state
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      chk("rst_cnt", 64'(cnt), 64'd0);
      chk("rst_k16", 64'(k16), 64'd0);
      chk("rst_rom_addr", 64'(rom_addr), 64'd0);
      chk("rst_illegal", 64'(ill), 64'd0);
      chk("rst_ack", 64'(pf_ack), 64'd0);
      chk("rst_uops", 64'({u0, u1, u2}), 64'({NOP, NOP, NOP}));

      // directed table, station always ready
      mon_en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         rom[tbl[i].opc] = tbl[i].word;
         byte_q.push_back(tbl[i].opc);
         if (tbl[i].nb > 0) byte_q.push_back(tbl[i].lo);
         if (tbl[i].nb > 1) byte_q.push_back(tbl[i].hi);
         exp_q.push_back('{tbl[i].ill, tbl[i].cnt, tbl[i].k16, tbl[i].u0, tbl[i].u1, tbl[i].u2});
         drain(100, 100, 100);
      end

      // 0-operand latency: opcode ack, ROM cycle, issue; next opcode acked right after capture
      rom[8'hAD] = rw(2'd2, 2'd3, 20'h11111, 20'h22222, 20'h33333);
      rom[8'hEA] = rw(2'd0, 2'd1, 20'h12345, 20'hAAAAA, 20'h55555);
      push_instr(8'hEA, 8'h00, 8'h00);
      push_instr(8'hAD, 8'h34, 8'h12);
      step(1'b1, 1'b1);
      chk("lat_opc_ack", 64'(pf_ack), 64'd1);
      step(1'b1, 1'b1);
      chk("lat_rom_noack", 64'(pf_ack), 64'd0);
      step(1'b1, 1'b1);
      chk("lat_issue_cnt", 64'(cnt), 64'd1);
      chk("lat_issue_noack", 64'(pf_ack), 64'd0);
      step(1'b1, 1'b1);
      chk("lat_cleared_cnt", 64'(cnt), 64'd0);
      chk("lat_next_opc_ack", 64'(pf_ack), 64'd1);
      drain(100, 100, 100);

      // prefetch gap between lo and hi, then station busy for 5 cycles
      rom[8'h90] = rw(2'd1, 2'd1, 20'h0ABCD, 20'h00000, 20'h00000);
      push_instr(8'hAD, 8'h34, 8'h12);
      push_instr(8'h90, 8'h5A, 8'h00);
      a0 = acks;
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      repeat (4) begin
         step(1'b0, 1'b0);
         chk("gap_noack", 64'(pf_ack), 64'd0);
         chk("gap_cnt", 64'(cnt), 64'd0);
      end
      step(1'b1, 1'b0);
      repeat (5) begin
         step(1'b1, 1'b0);
         chk("hold_noack", 64'(pf_ack), 64'd0);
         chk("hold_cnt", 64'(cnt), 64'd3);
         chk("hold_k16", 64'(k16), 64'h1234);
      end
      chk("ad_ack_pulses", 64'(acks - a0), 64'd3);
      step(1'b1, 1'b1);
      drain(100, 100, 100);
      chk("pre_rst_k16", 64'(k16), 64'h005A);

      // reset while waiting for the hi byte
      mon_en = 1'b0;
      byte_q.push_back(8'hAD);
      byte_q.push_back(8'h34);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      chk("shi_noack", 64'(pf_ack), 64'd0);
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0);
      chk("midrst_cnt", 64'(cnt), 64'd0);
      chk("midrst_k16", 64'(k16), 64'd0);
      chk("midrst_rom_addr", 64'(rom_addr), 64'd0);
      byte_q.delete();
      exp_q.delete();
      mon_en = 1'b1;
      push_instr(8'hEA, 8'h00, 8'h00);
      step(1'b1, 1'b1);
      chk("midrst_opc_ack", 64'(pf_ack), 64'd1);
      drain(100, 100, 100);

`ifdef ID_FLUSH_EN
      // flush beats capture and keeps the operand
      mon_en = 1'b0;
      byte_q.push_back(8'hAD);
      byte_q.push_back(8'h34);
      byte_q.push_back(8'h12);
      repeat (4) step(1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      chk("fl_issue_cnt", 64'(cnt), 64'd3);
      step(1'b0, 1'b0);
      chk("fl_cnt", 64'(cnt), 64'd0);
      chk("fl_k16_kept", 64'(k16), 64'h1234);
      chk("fl_uops", 64'({u0, u1, u2}), 64'({NOP, NOP, NOP}));
      push_instr(8'hEA, 8'h00, 8'h00);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      chk("fl_ack_blocked", 64'(pf_ack), 64'd0);
      mon_en = 1'b1;
      drain(100, 100, 100);
`endif

      // randomized stream with prefetch bubbles and a busy station
      for (int i = 0; i < 256; i++)
         rom[i] = rw(2'($urandom_range(3)),
                     ($urandom_range(9) == 0) ? 2'd0 : 2'($urandom_range(3, 1)),
                     20'($urandom), 20'($urandom), 20'($urandom));
      for (int i = 0; i < 150; i++)
         push_instr(8'($urandom), 8'($urandom), 8'($urandom));
      drain(20000, 70, 60);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
